// File: rtl/somador_serial.sv
// Bit-serial adder/subtractor: one full-adder stage, LSB first,
// WIDTH cycles per operation, registered result and flags.
module somador_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic fa_sum;
    logic fa_cry;

    // Operands shift right so the active bit is always bit 0.
    always_comb begin
        fa_sum = a_q[0] ^ b_q[0] ^ c_q;
        fa_cry = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    end

    // Next-state and datapath: latch on start, one bit per RUN cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    // Subtract is a + ~b + 1; cin plays no part then.
                    b_d     = sub ? ~b : b;
                    c_d     = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = fa_cry;
                cnt_d = cnt_q + CW'(1);
                acc_d = acc_q >> 1;
                acc_d[WIDTH-1] = fa_sum;
                if (cnt_q == LAST) begin
                    // c_q is the carry into the MSB here.
                    s_d     = acc_d;
                    cout_d  = fa_cry;
                    ovf_d   = c_q ^ fa_cry;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign s        = s_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_somador_serial.sv
// Bench for somador_serial: WIDTH=8 and WIDTH=1 instances checked
// every cycle against a transaction-level arithmetic model.
module tb_somador_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    logic       st8 = 0, ci8 = 0, sb8 = 0;
    logic [7:0] a8 = 0, b8 = 0;
    logic [7:0] s8;
    logic       co8, ov8, bz8, dn8;

    logic       st1 = 0, ci1 = 0, sb1 = 0;
    logic [0:0] a1 = 0, b1 = 0;
    logic [0:0] s1;
    logic       co1, ov1, bz1, dn1;

    int n_assert = 0;
    int n_fail   = 0;
    int n_done8  = 0;
    int n_done1  = 0;

    somador_serial #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8),
        .cin(ci8), .sub(sb8), .s(s8), .cout(co8),
        .overflow(ov8), .busy(bz8), .done(dn8)
    );

    somador_serial #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1),
        .cin(ci1), .sub(sb1), .s(s1), .cout(co1),
        .overflow(ov1), .busy(bz1), .done(dn1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Returns {overflow, cout, s} for a w-bit add/subtract.
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic cin, input logic sub);
        logic [63:0] mask, aa, bb, tot;
        logic [31:0] rs;
        logic        co, ov;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'd0, a} & mask;
        bb   = sub ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
        tot  = aa + bb + (sub ? 64'd1 : {63'd0, cin});
        rs   = tot[31:0] & mask[31:0];
        co   = tot[w];
        ov   = (aa[w-1] == bb[w-1]) && (rs[w-1] != aa[w-1]);
        return {ov, co, rs};
    endfunction

    // Reference model, WIDTH=8: result appears WIDTH cycles after accept.
    logic [7:0]  m8_s;
    logic        m8_co, m8_ov, m8_busy, m8_done;
    logic [33:0] m8_pend;
    int          m8_rem;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8_s <= 0; m8_co <= 0; m8_ov <= 0;
            m8_busy <= 0; m8_done <= 0; m8_rem <= 0; m8_pend <= 0;
        end else begin
            m8_done <= 0;
            if (!m8_busy) begin
                if (st8) begin
                    m8_pend <= ref_op(8, {24'd0, a8}, {24'd0, b8}, ci8, sb8);
                    m8_rem  <= 8;
                    m8_busy <= 1;
                end
            end else if (m8_rem == 1) begin
                m8_s    <= m8_pend[7:0];
                m8_co   <= m8_pend[32];
                m8_ov   <= m8_pend[33];
                m8_busy <= 0;
                m8_done <= 1;
                m8_rem  <= 0;
            end else begin
                m8_rem <= m8_rem - 1;
            end
        end
    end

    // Reference model, WIDTH=1.
    logic        m1_s, m1_co, m1_ov, m1_busy, m1_done;
    logic [33:0] m1_pend;
    int          m1_rem;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_s <= 0; m1_co <= 0; m1_ov <= 0;
            m1_busy <= 0; m1_done <= 0; m1_rem <= 0; m1_pend <= 0;
        end else begin
            m1_done <= 0;
            if (!m1_busy) begin
                if (st1) begin
                    m1_pend <= ref_op(1, {31'd0, a1}, {31'd0, b1}, ci1, sb1);
                    m1_rem  <= 1;
                    m1_busy <= 1;
                end
            end else if (m1_rem == 1) begin
                m1_s    <= m1_pend[0];
                m1_co   <= m1_pend[32];
                m1_ov   <= m1_pend[33];
                m1_busy <= 0;
                m1_done <= 1;
                m1_rem  <= 0;
            end else begin
                m1_rem <= m1_rem - 1;
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        chk("s8", {24'd0, s8}, {24'd0, m8_s});
        chk("cout8", {31'd0, co8}, {31'd0, m8_co});
        chk("ovf8", {31'd0, ov8}, {31'd0, m8_ov});
        chk("busy8", {31'd0, bz8}, {31'd0, m8_busy});
        chk("done8", {31'd0, dn8}, {31'd0, m8_done});
        chk("s1", {31'd0, s1}, {31'd0, m1_s});
        chk("cout1", {31'd0, co1}, {31'd0, m1_co});
        chk("ovf1", {31'd0, ov1}, {31'd0, m1_ov});
        chk("busy1", {31'd0, bz1}, {31'd0, m1_busy});
        chk("done1", {31'd0, dn1}, {31'd0, m1_done});
        if (dn8) n_done8++;
        if (dn1) n_done1++;
    end

    // Issue one WIDTH=8 op; optional junk start/operands at RUN cycle junk.
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic sb,
                       input int junk, output int lat);
        st8 = 1; a8 = a; b8 = b; ci8 = ci; sb8 = sb;
        @(posedge clk);
        #2 st8 = 0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (dn8) begin
                lat = k;
                chk("busy8 at done", {31'd0, bz8}, 0);
                break;
            end
            chk("busy8 in run", {31'd0, bz8}, 1);
            if (k == junk) begin
                st8 = 1; a8 = ~a; b8 = ~b; ci8 = ~ci; sb8 = ~sb;
            end else if (k == junk + 1) begin
                st8 = 0;
            end
        end
        st8 = 0;
        chk("latency8", lat, 8);
    endtask

    task automatic res8(input string nm, input logic [7:0] es,
                        input logic ec, input logic eo);
        chk({nm, " s"}, {24'd0, s8}, {24'd0, es});
        chk({nm, " cout"}, {31'd0, co8}, {31'd0, ec});
        chk({nm, " ovf"}, {31'd0, ov8}, {31'd0, eo});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int  lat;
        bit  saw;
        logic [1:0] tot;

        #12;
        chk("reset s8", {24'd0, s8}, 0);
        chk("reset busy8", {31'd0, bz8}, 0);
        chk("reset done8", {31'd0, dn8}, 0);
        @(posedge clk);
        #2 rst_n = 1;
        idle(1);

        op8(8'h0F, 8'h01, 0, 0, 0, lat); res8("add 0f+01", 8'h10, 0, 0);
        op8(8'hFF, 8'h01, 0, 0, 0, lat); res8("add ff+01", 8'h00, 1, 0);
        op8(8'h7F, 8'h00, 1, 0, 0, lat); res8("add 7f+00+1", 8'h80, 0, 1);
        op8(8'h05, 8'h07, 1, 1, 0, lat); res8("sub 05-07", 8'hFE, 0, 0);
        op8(8'h80, 8'h01, 0, 1, 0, lat); res8("sub 80-01", 8'h7F, 1, 1);
        idle(2);

        op8(8'h3C, 8'h5A, 0, 0, 3, lat); res8("junk 3c+5a", 8'h96, 0, 1);
        @(posedge clk);
        #1 chk("single done", {31'd0, dn8}, 0);
        res8("hold 3c+5a", 8'h96, 0, 1);
        idle(1);

        op8(8'h10, 8'h20, 0, 0, 0, lat); res8("b2b first", 8'h30, 0, 0);
        op8(8'hA0, 8'hB0, 0, 0, 0, lat); res8("b2b second", 8'h50, 1, 1);
        idle(1);

        st8 = 1; a8 = 8'hAA; b8 = 8'h55; ci8 = 1;
        @(posedge clk);
        #2 st8 = 0;
        repeat (4) @(posedge clk);
        #2 rst_n = 0;
        #1;
        res8("reset mid", 8'h00, 0, 0);
        chk("reset mid busy", {31'd0, bz8}, 0);
        chk("reset mid done", {31'd0, dn8}, 0);
        @(posedge clk);
        #2 rst_n = 1;
        saw = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1 if (dn8) saw = 1;
        end
        chk("no done after abort", {31'd0, saw}, 0);
        op8(8'h12, 8'h34, 1, 0, 0, lat); res8("after reset", 8'h47, 0, 0);
        idle(2);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            st1 = 1; a1 = v[2]; b1 = v[1]; ci1 = v[0]; sb1 = 0;
            @(posedge clk);
            #2 st1 = 0;
            lat = 0;
            for (int k = 1; k <= 5; k++) begin
                @(posedge clk);
                #1 if (dn1) begin lat = k; break; end
            end
            chk("latency1", lat, 1);
            tot = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
            chk("fa s", {31'd0, s1}, {31'd0, tot[0]});
            chk("fa cout", {31'd0, co1}, {31'd0, tot[1]});
            idle(1);
        end

        for (int c = 0; c < 3000; c++) begin
            st8 = ($urandom_range(3) == 0);
            a8  = 8'($urandom); b8 = 8'($urandom);
            ci8 = 1'($urandom); sb8 = 1'($urandom);
            st1 = ($urandom_range(2) == 0);
            a1  = 1'($urandom); b1 = 1'($urandom);
            ci1 = 1'($urandom); sb1 = 1'($urandom);
            @(posedge clk);
            #2;
        end
        st8 = 0; st1 = 0;
        idle(12);
        chk("random completions8", {31'd0, n_done8 > 150}, 1);
        chk("random completions1", {31'd0, n_done1 > 300}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
